// File: rtl/axis_dm_cmd_splitter_if.sv
// AXI-Stream style valid/ready/data bundle shared by the command and status paths.
interface axis_dm_cmd_splitter_if #(
  parameter int unsigned DATA_W = 8
) ();
  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tdata;

  modport master (output tvalid, output tdata, input tready);
  modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/axis_dm_cmd_splitter.sv
// Splits DataMover commands at C_MAX_BTT-aligned boundaries and merges the
// per-chunk statuses back into a single upstream status word.
module axis_dm_cmd_splitter #(
  parameter int unsigned C_CMD_WIDTH = 73,
  parameter int unsigned C_STS_WIDTH = 8,
  parameter int unsigned C_MAX_BTT   = 4096
) (
  input  logic                          clk,
  input  logic                          rst_n,
  axis_dm_cmd_splitter_if.slave         s_axis_cmd,
  axis_dm_cmd_splitter_if.master        m_axis_cmd,
  axis_dm_cmd_splitter_if.slave         s_axis_sts,
  axis_dm_cmd_splitter_if.master        m_axis_sts,
  output logic                          busy,
  output logic [15:0]                   sub_count
);

  localparam int unsigned BTT_W  = 23;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned TAG_W  = 4;
  localparam int unsigned ERR_W  = 3;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned CTL_W  = 8;
  localparam int unsigned OFF_W  = $clog2(C_MAX_BTT);
  localparam logic [BTT_W-1:0] MAX_BTT = BTT_W'(C_MAX_BTT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_STS, REPORT} state_e;

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [BTT_W-1:0]     rem_q, rem_d;
  logic [BTT_W-1:0]     chunk_q, chunk_d;
  logic [TAG_W-1:0]     tag_q, tag_d;
  logic                 eof_q, eof_d;
  logic                 pt_q, pt_d;
  logic [CTL_W-1:0]     ctl_q, ctl_d;      // {DRE, DSA[5:0], type}
  logic [ERR_W-1:0]     err_q, err_d;      // {SLVERR, DECERR, INTERR}
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [C_CMD_WIDTH-1:0] cmd_data_q, cmd_data_d;
  logic [C_STS_WIDTH-1:0] sts_data_q, sts_data_d;
  logic                 s_cmd_rdy_q, s_cmd_rdy_d;
  logic                 m_cmd_vld_q, m_cmd_vld_d;
  logic                 s_sts_rdy_q, s_sts_rdy_d;
  logic                 m_sts_vld_q, m_sts_vld_d;
  logic                 busy_q, busy_d;
  logic                 last_chunk_c;
  logic                 unused_bits;

  // Bytes left before the next aligned boundary, clipped to what remains.
  function automatic logic [BTT_W-1:0] chunk_of(input logic [OFF_W-1:0] off,
                                                input logic [BTT_W-1:0] rem);
    logic [BTT_W-1:0] space;
    space = MAX_BTT - BTT_W'(off);
    return (rem < space) ? rem : space;
  endfunction

  // Reserved command bits and the incoming OKAY bit carry no information here.
  assign unused_bits = ^{s_axis_cmd.tdata[71:68], s_axis_sts.tdata[7]};

  assign s_axis_cmd.tready = s_cmd_rdy_q;
  assign m_axis_cmd.tvalid = m_cmd_vld_q;
  assign m_axis_cmd.tdata  = cmd_data_q;
  assign s_axis_sts.tready = s_sts_rdy_q;
  assign m_axis_sts.tvalid = m_sts_vld_q;
  assign m_axis_sts.tdata  = sts_data_q;
  assign busy              = busy_q;
  assign sub_count         = cnt_q;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      chunk_q     <= '0;
      tag_q       <= '0;
      eof_q       <= 1'b0;
      pt_q        <= 1'b0;
      ctl_q       <= '0;
      err_q       <= '0;
      cnt_q       <= '0;
      cmd_data_q  <= '0;
      sts_data_q  <= '0;
      s_cmd_rdy_q <= 1'b0;
      m_cmd_vld_q <= 1'b0;
      s_sts_rdy_q <= 1'b0;
      m_sts_vld_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      chunk_q     <= chunk_d;
      tag_q       <= tag_d;
      eof_q       <= eof_d;
      pt_q        <= pt_d;
      ctl_q       <= ctl_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      cmd_data_q  <= cmd_data_d;
      sts_data_q  <= sts_data_d;
      s_cmd_rdy_q <= s_cmd_rdy_d;
      m_cmd_vld_q <= m_cmd_vld_d;
      s_sts_rdy_q <= s_sts_rdy_d;
      m_sts_vld_q <= m_sts_vld_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state, datapath updates and registered handshake outputs.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    rem_d        = rem_q;
    chunk_d      = chunk_q;
    tag_d        = tag_q;
    eof_d        = eof_q;
    pt_d         = pt_q;
    ctl_d        = ctl_q;
    err_d        = err_q;
    cnt_d        = cnt_q;
    cmd_data_d   = cmd_data_q;
    sts_data_d   = sts_data_q;
    last_chunk_c = 1'b0;

    case (state_q)
      IDLE: begin
        if (s_cmd_rdy_q && s_axis_cmd.tvalid) begin
          addr_d = s_axis_cmd.tdata[63:32];
          rem_d  = s_axis_cmd.tdata[22:0];
          tag_d  = s_axis_cmd.tdata[67:64];
          eof_d  = s_axis_cmd.tdata[30];
          pt_d   = s_axis_cmd.tdata[72];
          ctl_d  = {s_axis_cmd.tdata[31], s_axis_cmd.tdata[29:23]};
          err_d  = '0;
          cnt_d  = '0;
          if (s_axis_cmd.tdata[22:0] == '0) begin
            err_d   = ERR_W'(3'b001);
            state_d = REPORT;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (m_cmd_vld_q && m_axis_cmd.tready) begin
          addr_d  = addr_q + ADDR_W'(chunk_q);
          rem_d   = rem_q - chunk_q;
          cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
          state_d = WAIT_STS;
        end
      end
      WAIT_STS: begin
        if (s_sts_rdy_q && s_axis_sts.tvalid) begin
          err_d = err_q | s_axis_sts.tdata[6:4]
                | {2'b00, (s_axis_sts.tdata[3:0] != tag_q)};
          if ((err_d != '0) || (rem_q == '0)) state_d = REPORT;
          else                                state_d = ISSUE;
        end
      end
      REPORT: begin
        if (m_sts_vld_q && m_axis_sts.tready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Sub-command is built once on entry to ISSUE so it stays stable under backpressure.
    if ((state_d == ISSUE) && (state_q != ISSUE)) begin
      chunk_d      = chunk_of(addr_d[OFF_W-1:0], rem_d);
      last_chunk_c = (chunk_d == rem_d);
      cmd_data_d   = C_CMD_WIDTH'({pt_d, 4'h0, tag_d, addr_d, ctl_d[7],
                                   last_chunk_c & eof_d, ctl_d[6:0], chunk_d});
    end

    // Merged status is captured on entry to REPORT.
    if ((state_d == REPORT) && (state_q != REPORT)) begin
      sts_data_d = C_STS_WIDTH'({~|err_d, err_d, tag_d});
    end

    s_cmd_rdy_d = (state_d == IDLE);
    m_cmd_vld_d = (state_d == ISSUE);
    s_sts_rdy_d = (state_d == WAIT_STS);
    m_sts_vld_d = (state_d == REPORT);
    busy_d      = (state_d != IDLE);
  end

endmodule

// File: tb/tb_axis_dm_cmd_splitter.sv
// Bench for axis_dm_cmd_splitter: plays both the command master and the DataMover.
module tb_axis_dm_cmd_splitter;

  localparam int unsigned MAXB = 4096;

  logic        clk;
  logic        rst_n;
  logic        busy;
  logic [15:0] sub_count;

  axis_dm_cmd_splitter_if #(.DATA_W(73)) s_cmd_if ();
  axis_dm_cmd_splitter_if #(.DATA_W(73)) m_cmd_if ();
  axis_dm_cmd_splitter_if #(.DATA_W(8))  s_sts_if ();
  axis_dm_cmd_splitter_if #(.DATA_W(8))  m_sts_if ();

  axis_dm_cmd_splitter #(
    .C_CMD_WIDTH(73),
    .C_STS_WIDTH(8),
    .C_MAX_BTT  (MAXB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_axis_cmd(s_cmd_if),
    .m_axis_cmd(m_cmd_if),
    .s_axis_sts(s_sts_if),
    .m_axis_sts(m_sts_if),
    .busy      (busy),
    .sub_count (sub_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;

  // Per-transfer stimulus plan and observations
  logic [7:0]  sts_plan [$];
  logic [72:0] obs_cmds [$];
  logic [72:0] exp_cmds [$];
  logic [7:0]  obs_sts;
  logic [7:0]  exp_sts;
  int          n_up;
  int          viol;
  int          lat_first;
  int          lat_last;
  bit          timed_out;
  bit          post_ready;
  bit          post_busy;
  bit          post_sts_valid;
  logic [15:0] sub_cnt_end;

  function automatic logic [72:0] mk_cmd(input logic [31:0] a, input logic [22:0] b,
                                         input logic [3:0] tag, input logic eof);
    return {1'b0, 4'h0, tag, a, 1'b0, eof, 6'h00, 1'b0, b};
  endfunction

  // Status the DataMover returns for the i-th sub-command.
  function automatic logic [7:0] plan_sts(input int i, input logic [3:0] tag);
    if (i < sts_plan.size()) return sts_plan[i];
    return {4'b1000, tag};
  endfunction

  // Reference: walk the transfer in aligned pieces, stopping at the first error.
  task automatic model(input logic [72:0] cmd);
    logic [31:0] a;
    logic [22:0] rem;
    logic [22:0] len;
    logic [2:0]  err;
    logic [3:0]  tag;
    logic [72:0] e;
    logic [7:0]  st;
    int          i;
    a = cmd[63:32]; rem = cmd[22:0]; tag = cmd[67:64]; err = 3'b000; i = 0;
    exp_cmds.delete();
    if (rem == 23'h0) err = 3'b001;
    while (rem != 23'h0 && err == 3'b000) begin
      len = 23'(MAXB - (a % MAXB));
      if (len > rem) len = rem;
      e = cmd;
      e[71:68] = 4'h0;
      e[63:32] = a;
      e[22:0]  = len;
      e[30]    = (len == rem) ? cmd[30] : 1'b0;
      exp_cmds.push_back(e);
      st = plan_sts(i, tag);
      err = err | st[6:4];
      if (st[3:0] != tag) err[0] = 1'b1;
      a = a + 32'(len);
      rem = rem - len;
      i++;
    end
    exp_sts = {err == 3'b000, err, tag};
  endtask

  // Drive one command through the DUT, acting as master and DataMover; record what happens.
  task automatic do_xfer(input logic [72:0] cmd, input bit rnd_bp, input int hold_cmd,
                         input int hold_sts);
    int          cyc, acc_cyc, evt_cyc, chk_cyc, idx, cmd_hold, sts_hold;
    bit          accepted, done, cmd_wait, sts_wait, dm_present;
    logic [72:0] held_cmd;
    logic [7:0]  held_sts;
    logic [7:0]  pend [$];
    obs_cmds.delete(); obs_sts = 8'h00; n_up = 0; viol = 0; lat_first = -1; lat_last = -1;
    timed_out = 1'b0; cyc = 0; acc_cyc = 0; evt_cyc = 0; chk_cyc = -1; idx = 0;
    cmd_hold = 0; sts_hold = 0; accepted = 0; done = 0; cmd_wait = 0; sts_wait = 0;
    dm_present = 0; held_cmd = '0; held_sts = '0;
    while (!done) begin
      @(negedge clk);
      cyc++;
      if (cyc > 3000) begin timed_out = 1'b1; break; end
      if (cyc == chk_cyc && !(m_cmd_if.tvalid || m_sts_if.tvalid)) viol++;
      if (accepted && lat_first < 0 && (m_cmd_if.tvalid || m_sts_if.tvalid))
        lat_first = cyc - acc_cyc;
      // upstream command master
      if (accepted && s_cmd_if.tready) viol++;
      s_cmd_if.tvalid = !accepted;
      s_cmd_if.tdata  = accepted ? 73'h0 : cmd;
      if (!accepted && s_cmd_if.tready) begin
        accepted = 1; acc_cyc = cyc; evt_cyc = cyc; chk_cyc = cyc + 1;
      end
      // DataMover command port
      if (m_cmd_if.tvalid) begin
        if (!accepted) viol++;
        if (cmd_wait && m_cmd_if.tdata !== held_cmd) viol++;
        if (!cmd_wait) cmd_hold = hold_cmd;
        if (cmd_hold > 0) begin m_cmd_if.tready = 1'b0; cmd_hold--; end
        else m_cmd_if.tready = rnd_bp ? ($urandom_range(0, 2) != 0) : 1'b1;
        if (m_cmd_if.tready) begin
          obs_cmds.push_back(m_cmd_if.tdata);
          pend.push_back(plan_sts(idx, cmd[67:64]));
          idx++; cmd_wait = 0;
        end else begin
          cmd_wait = 1; held_cmd = m_cmd_if.tdata;
        end
      end else begin
        if (cmd_wait) viol++;
        cmd_wait = 0;
        m_cmd_if.tready = rnd_bp ? ($urandom_range(0, 1) != 0) : 1'b0;
      end
      // DataMover status port
      if (!dm_present && pend.size() > 0 && (!rnd_bp || $urandom_range(0, 1) == 0))
        dm_present = 1;
      s_sts_if.tvalid = dm_present;
      s_sts_if.tdata  = dm_present ? pend[0] : 8'h00;
      if (dm_present && s_sts_if.tready) begin
        void'(pend.pop_front());
        dm_present = 0; evt_cyc = cyc; chk_cyc = cyc + 1;
      end
      // upstream status consumer
      if (m_sts_if.tvalid) begin
        if (!accepted) viol++;
        if (sts_wait && m_sts_if.tdata !== held_sts) viol++;
        if (!sts_wait) begin sts_hold = hold_sts; lat_last = cyc - evt_cyc; end
        if (sts_hold > 0) begin m_sts_if.tready = 1'b0; sts_hold--; end
        else m_sts_if.tready = rnd_bp ? ($urandom_range(0, 2) != 0) : 1'b1;
        if (m_sts_if.tready) begin
          obs_sts = m_sts_if.tdata; n_up++; done = 1; sts_wait = 0;
        end else begin
          sts_wait = 1; held_sts = m_sts_if.tdata;
        end
      end else begin
        if (sts_wait) viol++;
        sts_wait = 0;
        m_sts_if.tready = rnd_bp ? ($urandom_range(0, 1) != 0) : 1'b0;
      end
    end
    @(negedge clk);
    post_ready = s_cmd_if.tready; post_busy = busy;
    post_sts_valid = m_sts_if.tvalid; sub_cnt_end = sub_count;
    s_cmd_if.tvalid = 1'b0; s_cmd_if.tdata = '0; m_cmd_if.tready = 1'b0;
    s_sts_if.tvalid = 1'b0; s_sts_if.tdata = '0; m_sts_if.tready = 1'b0;
    if (timed_out) begin
      rst_n = 1'b0; @(negedge clk); rst_n = 1'b1; @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    s_cmd_if.tvalid = 1'b0; s_cmd_if.tdata = '0; m_cmd_if.tready = 1'b0;
    s_sts_if.tvalid = 1'b0; s_sts_if.tdata = '0; m_sts_if.tready = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({s_cmd_if.tready, m_cmd_if.tvalid, s_sts_if.tready, m_sts_if.tvalid, busy} !== 5'b0) begin
      bad++;
      $display("FAIL reset_ctl got=%b want=00000", {s_cmd_if.tready, m_cmd_if.tvalid,
               s_sts_if.tready, m_sts_if.tvalid, busy});
    end
    total++;
    if ({m_cmd_if.tdata, m_sts_if.tdata, sub_count} !== 97'h0) begin
      bad++;
      $display("FAIL reset_data got cmd=%h sts=%h cnt=%h want 0", m_cmd_if.tdata,
               m_sts_if.tdata, sub_count);
    end
    rst_n = 1'b1;
    #1;
    total++;
    if (s_cmd_if.tready !== 1'b0) begin
      bad++; $display("FAIL reset_rdy_before_edge got=%b want=0", s_cmd_if.tready);
    end
    @(negedge clk);
    total++;
    if ({s_cmd_if.tready, busy} !== 2'b10) begin
      bad++; $display("FAIL reset_rdy_after_edge got=%b want=10", {s_cmd_if.tready, busy});
    end
  endtask

  task automatic test_single();
    logic [72:0] c;
    c = mk_cmd(32'h0000_1000, 23'h100, 4'd3, 1'b1);
    sts_plan.delete(); sts_plan.push_back(8'h83);
    model(c);
    do_xfer(c, 1'b0, 0, 0);
    total++;
    if (timed_out || viol != 0) begin
      bad++; $display("FAIL single_proto got timeout=%0d viol=%0d want 0/0", timed_out, viol);
    end
    total++;
    if (obs_cmds.size() != 1 || obs_cmds[0] !== exp_cmds[0]) begin
      bad++; $display("FAIL single_cmd got n=%0d c0=%h want n=1 c0=%h", obs_cmds.size(),
                      (obs_cmds.size() > 0) ? obs_cmds[0] : 73'h0, exp_cmds[0]);
    end
    total++;
    if (obs_sts !== 8'h83 || sub_cnt_end !== 16'd1) begin
      bad++; $display("FAIL single_sts got sts=%h cnt=%0d want 83/1", obs_sts, sub_cnt_end);
    end
    total++;
    if (lat_first != 1 || lat_last != 1) begin
      bad++; $display("FAIL single_lat got first=%0d last=%0d want 1/1", lat_first, lat_last);
    end
    total++;
    if ({post_ready, post_busy, post_sts_valid} !== 3'b100) begin
      bad++; $display("FAIL single_idle got=%b want=100", {post_ready, post_busy, post_sts_valid});
    end
  endtask

  task automatic test_split();
    logic [72:0] c;
    c = mk_cmd(32'h0000_0F00, 23'h2200, 4'd5, 1'b1);
    sts_plan.delete();
    for (int i = 0; i < 4; i++) sts_plan.push_back(8'h85);
    model(c);
    do_xfer(c, 1'b0, 0, 0);
    total++;
    if (timed_out || viol != 0) begin
      bad++; $display("FAIL split_proto got timeout=%0d viol=%0d want 0/0", timed_out, viol);
    end
    total++;
    if (obs_cmds.size() != 4) begin
      bad++; $display("FAIL split_count got=%0d want=4", obs_cmds.size());
    end
    for (int i = 0; i < obs_cmds.size() && i < exp_cmds.size(); i++) begin
      total++;
      if (obs_cmds[i] !== exp_cmds[i]) begin
        bad++; $display("FAIL split_cmd%0d got=%h want=%h", i, obs_cmds[i], exp_cmds[i]);
      end
    end
    total++;
    if (obs_sts !== 8'h85 || n_up != 1 || post_sts_valid || sub_cnt_end !== 16'd4) begin
      bad++; $display("FAIL split_sts got sts=%h n=%0d cnt=%0d want 85/1/4", obs_sts, n_up,
                      sub_cnt_end);
    end
  endtask

  task automatic test_error_abort();
    logic [72:0] c;
    c = mk_cmd(32'h0000_0F00, 23'h2200, 4'd5, 1'b1);
    sts_plan.delete(); sts_plan.push_back(8'h85); sts_plan.push_back(8'h45);
    model(c);
    do_xfer(c, 1'b0, 0, 0);
    total++;
    if (timed_out || viol != 0) begin
      bad++; $display("FAIL abort_proto got timeout=%0d viol=%0d want 0/0", timed_out, viol);
    end
    total++;
    if (obs_cmds.size() != 2 || sub_cnt_end !== 16'd2) begin
      bad++; $display("FAIL abort_count got n=%0d cnt=%0d want 2/2", obs_cmds.size(), sub_cnt_end);
    end
    total++;
    if (obs_sts !== 8'h45 || lat_last != 1) begin
      bad++; $display("FAIL abort_sts got sts=%h lat=%0d want 45/1", obs_sts, lat_last);
    end
  endtask

  task automatic test_zero_and_tag();
    logic [72:0] c;
    c = mk_cmd(32'h0000_2000, 23'h0, 4'd2, 1'b1);
    sts_plan.delete();
    model(c);
    do_xfer(c, 1'b0, 0, 0);
    total++;
    if (timed_out || viol != 0 || obs_cmds.size() != 0) begin
      bad++; $display("FAIL zero_proto got timeout=%0d viol=%0d ncmd=%0d want 0/0/0", timed_out,
                      viol, obs_cmds.size());
    end
    total++;
    if (obs_sts !== 8'h12 || lat_first != 1 || sub_cnt_end !== 16'd0) begin
      bad++; $display("FAIL zero_sts got sts=%h lat=%0d cnt=%0d want 12/1/0", obs_sts, lat_first,
                      sub_cnt_end);
    end
    c = mk_cmd(32'h0000_1000, 23'h100, 4'd3, 1'b1);
    sts_plan.delete(); sts_plan.push_back(8'h84);
    model(c);
    do_xfer(c, 1'b0, 0, 0);
    total++;
    if (timed_out || obs_sts !== 8'h13 || obs_cmds.size() != 1) begin
      bad++; $display("FAIL tag_mismatch got sts=%h n=%0d timeout=%0d want 13/1/0", obs_sts,
                      obs_cmds.size(), timed_out);
    end
  endtask

  task automatic test_backpressure_wrap();
    logic [72:0] c;
    c = mk_cmd(32'hFFFF_FF00, 23'h200, 4'd9, 1'b1);
    sts_plan.delete();
    model(c);
    do_xfer(c, 1'b0, 5, 4);
    total++;
    if (timed_out || viol != 0) begin
      bad++; $display("FAIL bp_proto got timeout=%0d viol=%0d want 0/0", timed_out, viol);
    end
    total++;
    if (obs_cmds.size() != 2 || exp_cmds.size() != 2) begin
      bad++; $display("FAIL wrap_count got=%0d want=2", obs_cmds.size());
    end else begin
      total++;
      if (obs_cmds[0][63:0] !== {32'hFFFF_FF00, 9'h000, 23'h100} ||
          obs_cmds[1] !== exp_cmds[1] || obs_cmds[1][63:32] !== 32'h0) begin
        bad++; $display("FAIL wrap_cmds got c0=%h c1=%h want c1=%h", obs_cmds[0], obs_cmds[1],
                        exp_cmds[1]);
      end
    end
    total++;
    if (obs_sts !== 8'h89) begin
      bad++; $display("FAIL bp_sts got=%h want=89", obs_sts);
    end
  endtask

  task automatic test_reset_mid();
    logic [72:0] c;
    bit          ok;
    c = mk_cmd(32'h0000_0F00, 23'h2200, 4'd5, 1'b1);
    s_cmd_if.tvalid = 1'b1; s_cmd_if.tdata = c; m_cmd_if.tready = 1'b0;
    ok = 0;
    for (int k = 0; k < 10; k++) begin
      if (s_cmd_if.tready) begin ok = 1; break; end
      @(negedge clk);
    end
    @(negedge clk);
    s_cmd_if.tvalid = 1'b0; s_cmd_if.tdata = '0; m_cmd_if.tready = 1'b1;
    total++;
    if (!ok || m_cmd_if.tvalid !== 1'b1) begin
      bad++; $display("FAIL rstmid_issue got accept=%0d vld=%b want 1/1", ok, m_cmd_if.tvalid);
    end
    @(negedge clk);
    m_cmd_if.tready = 1'b0;
    total++;
    if ({s_sts_if.tready, busy} !== 2'b11) begin
      bad++; $display("FAIL rstmid_wait got=%b want=11", {s_sts_if.tready, busy});
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({s_cmd_if.tready, m_cmd_if.tvalid, s_sts_if.tready, m_sts_if.tvalid, busy} !== 5'b0) begin
      bad++; $display("FAIL rstmid_clear got=%b want=00000", {s_cmd_if.tready, m_cmd_if.tvalid,
                      s_sts_if.tready, m_sts_if.tvalid, busy});
    end
    s_sts_if.tvalid = 1'b0; s_sts_if.tdata = '0; m_sts_if.tready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    c = mk_cmd(32'h0000_5000, 23'h80, 4'd7, 1'b1);
    sts_plan.delete();
    model(c);
    do_xfer(c, 1'b0, 0, 0);
    total++;
    if (timed_out || viol != 0 || obs_cmds.size() != 1 || obs_cmds[0] !== exp_cmds[0] ||
        obs_sts !== 8'h87 || sub_cnt_end !== 16'd1) begin
      bad++; $display("FAIL rstmid_after got timeout=%0d viol=%0d n=%0d sts=%h cnt=%0d want 0/0/1/87/1",
                      timed_out, viol, obs_cmds.size(), obs_sts, sub_cnt_end);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      logic [31:0] a;
      logic [22:0] b;
      logic [3:0]  tag;
      logic [72:0] c;
      int          m;
      int          r;
      tag = 4'($urandom);
      a = $urandom;
      m = int'($urandom_range(0, 3));
      if (m == 1) a[11:0] = 12'hFFF - 12'($urandom_range(0, 15));
      else if (m == 2) a[31:12] = 20'hFFFFF;
      b = 23'($urandom_range(1, 14336));
      if ($urandom_range(0, 9) == 0) b = 23'h0;
      c = {1'($urandom), 4'($urandom), tag, a, 1'($urandom), 1'($urandom), 6'($urandom),
           1'($urandom), b};
      sts_plan.delete();
      for (int i = 0; i < 8; i++) begin
        r = int'($urandom_range(0, 24));
        case (r)
          0:       sts_plan.push_back({4'b0100, tag});
          1:       sts_plan.push_back({4'b0010, tag});
          2:       sts_plan.push_back({4'b1000, tag ^ 4'h1});
          3:       sts_plan.push_back({4'b0001, tag});
          default: sts_plan.push_back({4'b1000, tag});
        endcase
      end
      model(c);
      do_xfer(c, 1'b1, 0, 0);
      total++;
      if (timed_out || viol != 0 || lat_first != 1) begin
        bad++; $display("FAIL rnd%0d_proto got timeout=%0d viol=%0d lat=%0d want 0/0/1", n,
                        timed_out, viol, lat_first);
      end
      total++;
      if (obs_cmds.size() != exp_cmds.size()) begin
        bad++; $display("FAIL rnd%0d_count got=%0d want=%0d", n, obs_cmds.size(), exp_cmds.size());
      end
      for (int i = 0; i < obs_cmds.size() && i < exp_cmds.size(); i++) begin
        total++;
        if (obs_cmds[i] !== exp_cmds[i]) begin
          bad++; $display("FAIL rnd%0d_cmd%0d got=%h want=%h", n, i, obs_cmds[i], exp_cmds[i]);
        end
      end
      total++;
      if (obs_sts !== exp_sts || n_up != 1 || post_sts_valid || !post_ready ||
          sub_cnt_end !== 16'(exp_cmds.size())) begin
        bad++; $display("FAIL rnd%0d_sts got sts=%h n=%0d cnt=%0d want sts=%h n=1 cnt=%0d", n,
                        obs_sts, n_up, sub_cnt_end, exp_sts, exp_cmds.size());
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    test_reset();
    test_single();
    test_split();
    test_error_abort();
    test_zero_and_tag();
    test_backpressure_wrap();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axis_dm_cmd_splitter.md
# axis_dm_cmd_splitter

Sits between the stream command master and the AXI DataMover, on both the command (73-bit) and status (8-bit) paths. Each upstream command whose transfer would exceed `C_MAX_BTT` or cross a `C_MAX_BTT`-aligned address boundary is split into aligned sub-commands. Sub-commands are issued one at a time. Their DataMover statuses are merged into exactly one status word returned upstream per accepted command.

## Interface
- `C_CMD_WIDTH`, 73: command width.
  - Fields: [72] passthrough; [71:68] reserved; [67:64] tag; [63:32] address; [31] DRE req; [30] EOF; [29:24] DSA; [23] type; [22:0] BTT.
- `C_STS_WIDTH`, 8: status width.
  - Fields: [7] OKAY; [6] SLVERR; [5] DECERR; [4] INTERR; [3:0] tag.
- `C_MAX_BTT`, 4096: maximum sub-command size in bytes. Must be a power of two, at most 2^22.

Ports:
- `clk`, in, 1: clock.
- `rst_n`, in, 1: reset. Asynchronous assert, active-low.
- `S_AXIS_CMD_TVALID` / `TREADY` / `TDATA`, in / out / in, 1 / 1 / 73: command from the master.
- `M_AXIS_CMD_TVALID` / `TREADY` / `TDATA`, out / in / out, 1 / 1 / 73: command to the DataMover.
- `S_AXIS_STS_TVALID` / `TREADY` / `TDATA`, in / out / in, 1 / 1 / 8: status from the DataMover.
- `M_AXIS_STS_TVALID` / `TREADY` / `TDATA`, out / in / out, 1 / 1 / 8: merged status to the master.
- `busy`, out, 1: high in any state other than IDLE.
- `sub_count`, out, 16: number of sub-commands issued for the current command. Cleared on accept, saturates at 0xFFFF.

## Operation
- States: IDLE, ISSUE, WAIT_STS, REPORT.
- **IDLE**
  - `S_AXIS_CMD_TREADY` = 1.
  - On handshake, latch address, BTT, tag, EOF, and bits [72], [31:23] into registers.
  - Clear the error accumulator and `sub_count`.
  - If BTT = 0: go to REPORT with INTERR = 1.
  - Otherwise: go to ISSUE.
- **Chunk size**: chunk = min(remaining, C_MAX_BTT − (addr mod C_MAX_BTT)).
  - Computed and registered on entry to ISSUE.
  - Remaining is 23-bit. Address arithmetic is 32-bit modulo 2^32 (wraps 0xFFFFFFFF→0).
- **ISSUE**
  - `M_AXIS_CMD_TVALID` = 1.
  - TDATA = latched fields, with [63:32] = current address and [22:0] = chunk.
  - [30] = latched EOF only when chunk = remaining; 0 otherwise.
  - Tag is unchanged.
  - On handshake: address += chunk, remaining −= chunk, `sub_count`++, go to WAIT_STS.
- **WAIT_STS**
  - `S_AXIS_STS_TREADY` = 1.
  - On handshake, OR bits [6:4] into the accumulator.
  - If the returned tag ≠ latched tag, set INTERR.
  - If the accumulated error ≠ 0 or remaining = 0: go to REPORT. Remaining chunks are abandoned and never issued.
  - Otherwise: go to ISSUE.
- **REPORT**
  - `M_AXIS_STS_TVALID` = 1.
  - TDATA = {~|err, err[2:0], tag}.
  - On handshake: go to IDLE.
- Upstream TREADY, downstream TVALID, and status TREADY are asserted only in the states listed above.

## Timing
- All outputs are registered or decoded from the registered state. There are no combinational paths from inputs to outputs.
- Reset (`rst_n` low, asynchronous):
  - State = IDLE.
  - All TVALID and TREADY outputs = 0 while `rst_n` is low.
  - TDATA outputs = 0, `busy` = 0, `sub_count` = 0.
  - `S_AXIS_CMD_TREADY` rises on the first clock edge after deassertion.
- Reset mid-transfer discards the in-flight command with no upstream status. The bench must also reset the DataMover.
- Latency:
  - Upstream accept → first `M_AXIS_CMD_TVALID`: 1 cycle.
  - Status handshake → next sub-command TVALID: 1 cycle.
  - Last status → `M_AXIS_STS_TVALID`: 1 cycle.
  - BTT = 0 accept → status valid: 1 cycle.
- Valid/data stability:
  - `M_AXIS_CMD_TDATA` is stable while TVALID is high and TREADY is low.
  - `M_AXIS_STS_TDATA` is stable while TVALID is high and TREADY is low.
  - No valid drops without a handshake.
- Only one command is in flight. `S_AXIS_CMD_TREADY` stays low from accept until the cycle after the REPORT handshake.
- A status arriving outside WAIT_STS is not accepted (TREADY = 0). It stalls until WAIT_STS.

## Test plan
- **Single chunk**:
  - Stimulus: addr 0x00001000, BTT 0x100, tag 3, EOF 1.
  - Response: one command with addr 0x1000, BTT 0x100, [30] = 1, tag 3.
  - DataMover status 0x83 → upstream 0x83, `sub_count` = 1.
- **Split**:
  - Stimulus: addr 0x00000F00, BTT 0x2200, tag 5, EOF 1.
  - Response: four commands, in order:
    - 0x100 @ 0x0F00, EOF 0
    - 0x1000 @ 0x1000, EOF 0
    - 0x1000 @ 0x2000, EOF 0
    - 0x100 @ 0x3000, EOF 1
  - Statuses 0x85 ×4 → one upstream 0x85, `sub_count` = 4.
- **Error abort**:
  - Stimulus: as Split, with the second status 0x45.
  - Response: no third command; upstream 0x45 one cycle later.
- **Zero length and tag mismatch**:
  - BTT 0, tag 2 → no downstream command, upstream 0x12.
  - Separately, a single chunk with tag 3 returned with status 0x84 → upstream 0x13.
- **Backpressure and wrap**:
  - Stimulus: addr 0xFFFFFF00, BTT 0x200.
  - Response: 0x100 @ 0xFFFFFF00, then 0x100 @ 0x00000000.
  - Hold `M_AXIS_CMD_TREADY` low 5 cycles → TDATA stable and upstream TREADY = 0.
  - Hold `M_AXIS_STS_TREADY` low 4 cycles → status held.
- **Reset mid-operation**:
  - Drop `rst_n` in WAIT_STS → all valids 0 immediately, `busy` = 0.
  - After release, a single-chunk command completes normally.
